// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter feeding one UART TX core
// UART_ARB_TIMEOUT_EN builds the HOLD idle counter that releases a stalled frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 52083
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 arb_busy,
  output logic                 timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_START, S_WAIT_HI, S_WAIT_LO, S_HOLD
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, grant_nx, rr_pick, grant_inc;
  logic [IDX_W:0]   cand;
  logic             rr_found;
  logic             last_q, last_nx;
  logic [7:0]       data_nx;
  logic             timeout_nx;
  logic             hold_expired;

  // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = ptr;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!rr_found && req_valid[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_inc = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == S_HOLD && state_nx == S_HOLD) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  assign hold_expired = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant_id;
    data_nx    = tx_data;
    last_nx    = last_q;
    timeout_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (rr_found) begin
          grant_nx = rr_pick;
          state_nx = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (req_valid[grant_id]) begin
          data_nx  = req_data[8*grant_id +: 8];
          last_nx  = req_last[grant_id];
          state_nx = S_START;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx_busy) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_nx   = grant_inc;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A byte arriving on the expiry cycle takes precedence over the timeout.
        if (req_valid[grant_id]) begin
          state_nx = S_ACCEPT;
        end else if (hold_expired) begin
          timeout_nx = 1'b1;
          ptr_nx     = grant_inc;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= 8'h00;
      last_q   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      grant_id <= grant_nx;
      tx_data  <= data_nx;
      last_q   <= last_nx;
      timeout  <= timeout_nx;
    end
  end

  assign req_ready = (state == S_ACCEPT) ? (NUM_REQ'(1) << grant_id) : '0;
  assign tx_start  = (state == S_START);
  assign arb_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a byte-timed TX core model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   drv_valid, pulse_mask, req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic            tx_start, tx_busy, arb_busy, timeout;
  logic [7:0]      tx_data;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;
  assign req_valid = drv_valid | pulse_mask;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout(timeout)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [3:0] exp_ready;
    int         exp_grant;
  } vec_t;

  vec_t       tbl[4];
  logic [8:0] fq[NR][$];
  int         sb[$];
  int         checks = 0;
  int         passed = 0;
  int         starts = 0;
  int         ready_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic last, input logic expect_out);
    fq[idx].push_back({last, d});
    if (expect_out) sb.push_back(idx * 256 + int'(d));
  endtask

  function automatic logic queues_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (fq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NR; i++) fq[i].delete();
    sb.delete();
    pulse_mask = '0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !queues_empty() || arb_busy || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 3000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_all();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester model: each queue front is presented until accepted.
  initial begin
    logic [NR-1:0] acc;
    logic [8:0]    f;
    drv_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & drv_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (acc[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (fq[i].size() > 0) begin
          f = fq[i][0];
          drv_valid[i] = 1'b1;
          req_data[8*i +: 8] = f[7:0];
          req_last[i] = f[8];
        end else begin
          drv_valid[i] = 1'b0;
        end
      end
    end
  end

  // TX core model: busy for 6 cycles starting the cycle after tx_start.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        starts++;
        if (sb.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tx_grant_byte", 32'(int'(grant_id) * 256 + int'(tx_data)), 32'(e));
        end
      end
      if (!$onehot0(req_ready)) ready_bad++;
      if (req_ready[2] && fq[1].size() > 0) ready_bad++;
    end
  end

  initial begin
    int n, s0, pulses, at;
    rst_n      = 1'b0;
    pulse_mask = '0;
    tbl[0] = '{idx: 2, data: 8'hA1, exp_ready: 4'b0100, exp_grant: 2};
    tbl[1] = '{idx: 3, data: 8'hFF, exp_ready: 4'b1000, exp_grant: 3};
    tbl[2] = '{idx: 1, data: 8'h7E, exp_ready: 4'b0010, exp_grant: 1};
    tbl[3] = '{idx: 0, data: 8'h34, exp_ready: 4'b0001, exp_grant: 0};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-byte frames: ready at n+1, tx_start at n+2, release afterwards.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      push(tbl[v].idx, tbl[v].data, 1'b1, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!req_valid[tbl[v].idx] && n < 10);
      check("vec_valid_seen", 32'(n < 10), 1);
      check("vec_idle_busy", 32'(arb_busy), 0);
      check("vec_idle_ready", 32'(req_ready), 0);
      @(negedge clk);
      check("vec_ready", 32'(req_ready), 32'(tbl[v].exp_ready));
      check("vec_grant", 32'(grant_id), 32'(tbl[v].exp_grant));
      @(negedge clk);
      check("vec_tx_start", 32'(tx_start), 1);
      wait_done("vec_done");
      check("vec_released", 32'(arb_busy), 0);
    end

    // ptr is now 1: requester 1 must beat requester 0.
    push(1, 8'h21, 1'b1, 1'b1);
    push(0, 8'h20, 1'b1, 1'b1);
    wait_done("ptr_order_done");

    // Leave ptr at 2, then reset: the round must start from requester 0.
    push(1, 8'h31, 1'b1, 1'b1);
    wait_done("pre_reset_done");
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 8'(8'h10 + i), 1'b1, 1'b1);
    wait_done("simul_round_done");

    // Frame lock: requester 1 sends three bytes while requester 2 waits.
    push(1, 8'h1C, 1'b0, 1'b1);
    push(1, 8'h38, 1'b0, 1'b1);
    push(1, 8'h2C, 1'b1, 1'b1);
    push(2, 8'h55, 1'b1, 1'b1);
    wait_done("frame_lock_done");
    check("ready_lock_onehot", 32'(ready_bad), 0);

    // Withdrawn valid: ptr is 3; a one-cycle pulse from req3 must not transmit.
    s0 = starts;
    @(posedge clk);
    #1 pulse_mask = 4'b1000;
    @(negedge clk);
    check("wd_idle", 32'(arb_busy), 0);
    @(posedge clk);
    #1 pulse_mask = 4'b0000;
    @(negedge clk);
    check("wd_ready", 32'(req_ready), 32'(4'b1000));
    check("wd_grant", 32'(grant_id), 3);
    repeat (10) @(negedge clk);
    check("wd_no_start", 32'(starts - s0), 0);
    check("wd_back_idle", 32'(arb_busy), 0);
    push(3, 8'h3D, 1'b1, 1'b1);
    push(0, 8'h0D, 1'b1, 1'b1);
    wait_done("wd_ptr_done");

    // Reset while waiting for the TX core to finish the first byte of a frame.
    push(0, 8'hAA, 1'b0, 1'b1);
    push(0, 8'hBB, 1'b1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_busy && n < 100);
    check("rm_tx_busy_seen", 32'(n < 100), 1);
    repeat (2) @(negedge clk);
    check("rm_in_frame", 32'(arb_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rm_arb_busy", 32'(arb_busy), 0);
    check("rm_req_ready", 32'(req_ready), 0);
    check("rm_tx_start", 32'(tx_start), 0);
    check("rm_tx_data", 32'(tx_data), 0);
    check("rm_grant_id", 32'(grant_id), 0);
    clear_all();
    s0 = starts;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rm_no_start", 32'(starts - s0), 0);
    check("rm_idle", 32'(arb_busy), 0);
    wait_done("rm_settled");

    // HOLD with requester 0 gone quiet while requester 1 is pending.
    push(0, 8'h5A, 1'b0, 1'b1);
    fq[1].push_back({1'b1, 8'h61});
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_busy && n < 100);
    do begin @(negedge clk); n++; end while (tx_busy && n < 200);
    check("to_byte_sent", 32'(n < 200), 1);
    pulses = 0;
    at = 0;
`ifdef UART_ARB_TIMEOUT_EN
    sb.push_back(1 * 256 + 8'h61);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (timeout) begin pulses++; at = k; end
    end
    check("to_pulse_count", 32'(pulses), 1);
    check("to_pulse_cycle", 32'(at), 17);
`else
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (timeout) pulses++;
    end
    check("no_to_pulse", 32'(pulses), 0);
    check("no_to_still_held", 32'(arb_busy), 1);
    push(0, 8'h5B, 1'b1, 1'b1);
    sb.push_back(1 * 256 + 8'h61);
`endif
    wait_done("to_done");
    check("ready_final_onehot", 32'(ready_bad), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, checks);
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter (9600 baud, 50 MHz `clk`) between several on-chip byte sources. It accepts byte-wide frames from up to NUM_REQ requesters and holds the grant for the whole frame, so multi-byte messages are never interleaved. It issues one `tx_start` pulse per byte and sequences the next byte from `tx_busy`. It sits between the command/status producers and the UART TX core in TOP, mirroring the RX path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 2, width of grant index (clog2(NUM_REQ))
- TIMEOUT_CYCLES, 52083, HOLD-state idle limit (about 1 byte time at 9600 baud on 50 MHz)
- clk  input  1  system clock; one clock domain
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  byte of requester i on [8i+7:8i]
- req_last  input  NUM_REQ  byte is last of its frame
- req_ready  output  NUM_REQ  one-hot; byte of requester i is accepted when valid & ready
- tx_start  output  1  one-cycle pulse to the UART TX core
- tx_data  output  8  byte for the TX core; stable from tx_start until return to IDLE/HOLD
- tx_busy  input  1  TX core busy (start bit to end of stop bit)
- grant_id  output  IDX_W  current owner index
- arb_busy  output  1  high in every state except IDLE
- timeout  output  1  one-cycle pulse when a held grant is released by timeout

## Operation
- States: IDLE, ACCEPT, START, WAIT_HI, WAIT_LO, HOLD.
- IDLE: if any req_valid, grant_id <= first set bit searching ptr, ptr+1, ... mod NUM_REQ. Go to ACCEPT.
- ACCEPT: req_ready[grant_id]=1 (decoded from registered state, no input-to-output path).
  - If req_valid[grant_id]: latch data and last. Go to START.
  - Otherwise return to IDLE with ptr unchanged.
- START: tx_start=1 for exactly this cycle. Go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0.
  - If latched last=1: ptr <= grant_id+1 (mod NUM_REQ). Go to IDLE.
  - Else go to HOLD.
- HOLD: other requesters are ignored. When req_valid[grant_id]=1, go to ACCEPT.
- Only the granted requester ever sees ready. All other req_ready bits are 0 in every state.
- Simultaneous requests: the lowest index at or after ptr wins. A new request arriving in any non-IDLE state waits.
- Single-byte frames (last=1 on the first byte) release immediately after that byte.

## Timing
- Reset values: state=IDLE, ptr=0, grant_id=0, tx_start=0, tx_data=8'h00, req_ready=0, arb_busy=0, timeout=0, hold counter=0.
- Reset asserted mid-frame aborts immediately: tx_start is never emitted afterwards, and the partial frame is dropped.
- Latency from request to start:
  - Valid seen in IDLE at cycle n: ready at n+1, tx_start at n+2.
  - Within a frame, next byte valid in HOLD at cycle m: ready at m+1, tx_start at m+2.
- Byte-to-byte gap: at least 3 clk after tx_busy falls.
- grant_id changes only on the IDLE->ACCEPT transition.
- ptr changes only on release (last byte done or timeout).

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - The hold counter counts clk cycles in HOLD and clears on leaving HOLD.
  - When it reaches TIMEOUT_CYCLES-1 with no req_valid[grant_id], the block pulses timeout, sets ptr <= grant_id+1, and goes to IDLE.
  - If req_valid[grant_id] arrives on that same cycle, the valid wins and there is no timeout.
- Not defined: no counter is built, timeout is tied 0, and HOLD waits indefinitely.

## Test plan
- Single request: req0 sends 8'h34 with last=1. Required: ready0 at +1, tx_start with tx_data=8'h34 at +2, and after tx_busy falls arb_busy=0 with ptr=1.
- Simultaneous req0..req3, each one byte (8'h10..8'h13) with last=1. Required: tx_data sequence 10,11,12,13; a second round after reset starts at 10.
- Frame lock: req1 sends 3 bytes (8'h1C, 8'h38, 8'h2C, last on the third) while req2 is valid throughout. Required: all three req1 bytes go out before any req2 byte, and req_ready[2] stays 0 until then.
- Valid withdrawn: req3 asserts valid then drops it before ACCEPT. Required: return to IDLE, no tx_start, ptr unchanged.
- Reset mid-frame: rst_n=0 while in WAIT_LO. Required: all outputs at reset values the same cycle, and no further tx_start.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req0 sends a non-last byte then goes idle. Required: timeout pulses once 16 cycles after entering HOLD, and a pending req1 is granted next.
